resp_window_monitor: RTL
========================

# resp_window_monitor

Synthesizable bounded-response checker that enforces "whenever `req` is sampled high, `ack` must be sampled high between MIN_DLY and MAX_DLY clocks later", using the same semantics as a concurrent `req |-> ##[MIN_DLY:MAX_DLY] ack` assertion. It sits downstream of any req/ack producer and consumes its two handshake wires. It reports per-cycle pass/fail pulses and saturating statistics, so the same check runs in silicon and emulation, not only in simulation.

## Interface
- MIN_DLY, 1: earliest cycle offset at which `ack` satisfies an attempt; legal range 1..MAX_DLY.
- MAX_DLY, 5: latest cycle offset; legal range MIN_DLY..32.
- CNT_W, 16: width of the pass/fail counters.
- clk  in  1  single clock; all sampling on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  when low, no new attempts start; outstanding attempts continue to resolve.
- clr  in  1  synchronous clear of counters and `err_sticky`; pending attempts are kept.
- req  in  1  antecedent, sampled at posedge clk.
- ack  in  1  consequent, sampled at posedge clk.
- pass_pulse  out  1  one or more attempts passed in the previous sample.
- fail_pulse  out  1  one or more attempts failed in the previous sample.
- pass_cnt  out  CNT_W  saturating count of passed attempts.
- fail_cnt  out  CNT_W  saturating count of failed attempts.
- pending  out  6  number of outstanding attempts (0..MAX_DLY).
- err_sticky  out  1  set by the first failure; cleared only by `clr` or reset.

## Operation
- Attempt tracking uses the vector `pend[1..MAX_DLY]`. `pend[k]=1` means an attempt started k samples ago and is still unresolved. Each `req` sample opens an independent attempt, so overlapping attempts are allowed.
- At every posedge, with sampled `req` and `ack`:
  - Passing set: `pend[k] & ack` for MIN_DLY ≤ k ≤ MAX_DLY. A single `ack` satisfies all of these at once.
  - Failing set: `pend[MAX_DLY] & ~ack`.
  - Next state:
    - `pend[1] ← req & en`.
    - `pend[k+1] ← pend[k] & ~(ack & k ≥ MIN_DLY)` for k < MAX_DLY.
    - The bit aged out of MAX_DLY is dropped after being resolved.
- An `ack` sampled in the same cycle as `req` never satisfies that attempt, because the minimum offset is 1.
- An `ack` at age k < MIN_DLY does not satisfy the attempt. The attempt stays pending.
- Counters:
  - `pass_cnt` adds the popcount of the passing set; `fail_cnt` adds the popcount of the failing set.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- `clr`:
  - Zeroes both counters and `err_sticky` for that edge.
  - Any passes or fails resolved on the same edge are discarded, not counted.
- `pending` is the popcount of `pend` after the update.
- Reset, including mid-operation, clears `pend` entirely. Outstanding attempts are abandoned: they count as neither pass nor fail.

## Timing
- Reset values: `pend`=0, `pass_pulse`=0, `fail_pulse`=0, `pass_cnt`=0, `fail_cnt`=0, `pending`=0, `err_sticky`=0.
- All outputs are registered, with 1-cycle latency from the deciding sample.
  - A fail decided at edge t+MAX_DLY for `req` at edge t shows `fail_pulse`=1 during the cycle after edge t+MAX_DLY.
  - Counters update on that same edge.
- `pass_pulse` and `fail_pulse` may be high in the same cycle, because different attempts can resolve differently.
- `en` low on the edge that samples `req` suppresses only that attempt.
- There is no other handshake. The block never back-pressures.

## Structure
- Package `resp_mon_pkg` holds:
  - the `MAX_DLY_LIMIT` constant (32);
  - the `pend_vec_t` typedef;
  - the `popcount` function used for the pass/fail/pending sums.
- Sub-module `sat_counter` (parameter W, inputs `inc[5:0]` and `clr`) is instantiated twice, once for `pass_cnt` and once for `fail_cnt`.
- Parameter legality is checked with elaboration-time `$error`.

## Test plan
- Defaults. `req`=1 for one sample at edge 2, `ack`=1 first at edge 5 → `pass_pulse`=1 after edge 5, `pass_cnt`=1, `fail_cnt`=0, `err_sticky`=0.
- Defaults. `req`=1 at edge 2, `ack` held low until edge 8 → `fail_pulse`=1 after edge 7, `fail_cnt`=1, `err_sticky`=1; the later `ack` adds no pass.
- `req` held high for edges 2..5, single `ack` at edge 6 → one pulse with `pass_cnt`=4, `pending` returns to 0.
- `req` and `ack` both high only at edge 3, MIN_DLY=2 with `ack` again at edge 4 → no pass at edges 3/4; the attempt fails after edge 3+MAX_DLY, so `fail_cnt`=1.
- CNT_W=3: seven passes then three more → `pass_cnt` stays at 7. Then `clr`=1 on the same edge as a fail → counters=0, `err_sticky`=0.
- `req` at edge 2, `rst_n` asserted low mid-window at edge 4, released, no `ack` → `pending`=0 and all outputs at reset values immediately. No `fail_pulse` ever appears for the abandoned attempt.

Source files
------------

// File: rtl/resp_window_monitor_pkg.sv
// Shared constants, the attempt-vector type and the popcount helper used for
// the pass/fail/pending sums of the response-window monitor.
package resp_mon_pkg;

   localparam int unsigned MAX_DLY_LIMIT = 32;
   localparam int unsigned CNT_INC_W     = 6;

   // Bit k set: an attempt opened k samples ago is still unresolved.
   typedef logic [MAX_DLY_LIMIT:1] pend_vec_t;

   function automatic logic [CNT_INC_W-1:0] popcount(input pend_vec_t v);
      logic [CNT_INC_W-1:0] n;
      n = '0;
      for (int unsigned i = 1; i <= MAX_DLY_LIMIT; i++) begin
         n = n + CNT_INC_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/resp_window_monitor_if.sv
// req/ack handshake observed by the monitor.
//   req : antecedent, sampled on posedge clk
//   ack : consequent, sampled on posedge clk
// master: the req/ack producer; slave: the monitor (observe only).
interface resp_window_monitor_if;
   logic req;
   logic ack;

   modport master (output req, output ack);
   modport slave  (input  req, input  ack);
endinterface

// File: rtl/resp_window_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : amount to add this edge (0..32)
//   clr        : zero the count; inc on the same edge is discarded
//   cnt        : registered count, holds at 2^W-1
module sat_counter
   import resp_mon_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CNT_INC_W-1:0] inc,
   input  logic                 clr,
   output logic [W-1:0]         cnt
);

   // One bit of headroom over the wider operand so the sum cannot wrap.
   localparam int unsigned SW = ((W > CNT_INC_W) ? W : CNT_INC_W) + 1;
   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [SW-1:0] sum_c;

   assign sum_c = SW'(cnt) + SW'(inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (sum_c > SW'(CNT_MAX)) begin
         cnt <= CNT_MAX;
      end else begin
         cnt <= W'(sum_c);
      end
   end

endmodule

// File: rtl/resp_window_monitor.sv
// Bounded-response checker: every sampled req must see ack sampled between
// MIN_DLY and MAX_DLY clocks later. Overlapping attempts tracked independently.
//   clk, rst_n : clock, async active-low reset (abandons open attempts)
//   en         : low suppresses starting a new attempt on that edge
//   clr        : sync clear of counters and err_sticky
//   hs         : req/ack handshake (slave modport)
//   pass_pulse / fail_pulse : some attempt passed / failed at the previous edge
//   pass_cnt / fail_cnt     : saturating attempt counts
//   pending    : open attempts after the update
//   err_sticky : set by any failure, cleared by clr or reset
module resp_window_monitor
   import resp_mon_pkg::*;
#(
   parameter int unsigned MIN_DLY = 1,
   parameter int unsigned MAX_DLY = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   resp_window_monitor_if.slave  hs,
   output logic                  pass_pulse,
   output logic                  fail_pulse,
   output logic [CNT_W-1:0]      pass_cnt,
   output logic [CNT_W-1:0]      fail_cnt,
   output logic [CNT_INC_W-1:0]  pending,
   output logic                  err_sticky
);

   if (MIN_DLY < 1 || MIN_DLY > MAX_DLY) begin : g_bad_min
      $error("resp_window_monitor: MIN_DLY must be in 1..MAX_DLY");
   end
   if (MAX_DLY > MAX_DLY_LIMIT) begin : g_bad_max
      $error("resp_window_monitor: MAX_DLY must not exceed MAX_DLY_LIMIT");
   end

   pend_vec_t pend_q;
   pend_vec_t pend_n;
   pend_vec_t win_mask;
   pend_vec_t pass_set;
   logic      fail_c;

   // Resolve the current ages against ack and shift the survivors one age up.
   always_comb begin
      win_mask = '0;
      for (int unsigned k = 1; k <= MAX_DLY; k++) begin
         win_mask[k] = (k >= MIN_DLY);
      end

      pass_set = hs.ack ? (pend_q & win_mask) : '0;
      fail_c   = pend_q[MAX_DLY] & ~hs.ack;

      pend_n    = '0;
      pend_n[1] = hs.req & en;
      for (int unsigned k = 1; k < MAX_DLY; k++) begin
         pend_n[k + 1] = pend_q[k] & ~(hs.ack & (k >= MIN_DLY));
      end
   end

   // Attempt vector and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q     <= '0;
         pass_pulse <= 1'b0;
         fail_pulse <= 1'b0;
         pending    <= '0;
         err_sticky <= 1'b0;
      end else begin
         pend_q     <= pend_n;
         pass_pulse <= |pass_set;
         fail_pulse <= fail_c;
         pending    <= popcount(pend_n);
         err_sticky <= clr ? 1'b0 : (err_sticky | fail_c);
      end
   end

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (popcount(pass_set)),
      .clr   (clr),
      .cnt   (pass_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (CNT_INC_W'(fail_c)),
      .clr   (clr),
      .cnt   (fail_cnt)
   );

endmodule
